reorder_buffer: RTL and testbench

- Circular in-order retirement queue of the Tomasulo core. It sits between the dispatcher (allocation), the CDB (writeback) and the register file (commit).
- Allocates one tag per dispatched instruction and captures results from the CDB.
- Retires the head entry in program order, driving rd/value/tag to the register file.
- On a mispredicted branch at the head, raises rollback with the correct PC and flushes every entry.

---
 rtl/reorder_buffer_if.sv | 47 ++++
 rtl/reorder_buffer.sv | 168 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatcher / CDB / commit bundle of the reorder buffer.
// master = environment side, slave = the reorder buffer itself.
interface reorder_buffer_if #(
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_rd;
  logic [1:0]        alloc_type;
  logic              alloc_pred_taken;
  logic [ROB_W-1:0]  alloc_tag;
  logic              full;
  logic [ROB_W-1:0]  query_tag1, query_tag2;
  logic              query_ready1, query_ready2;
  logic [DATA_W-1:0] query_value1, query_value2;
  logic              wb_valid;
  logic [ROB_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_value;
  logic              wb_taken;
  logic [31:0]       wb_redirect_pc;
  logic              commit_flag;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_value;
  logic [ROB_W-1:0]  commit_tag;
  logic              store_commit;
  logic              rollback_flag;
  logic [31:0]       rollback_pc;

  modport master (
    output alloc_valid, alloc_rd, alloc_type, alloc_pred_taken,
           query_tag1, query_tag2,
           wb_valid, wb_tag, wb_value, wb_taken, wb_redirect_pc,
    input  alloc_tag, full, query_ready1, query_ready2, query_value1, query_value2,
           commit_flag, commit_rd, commit_value, commit_tag, store_commit,
           rollback_flag, rollback_pc
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_type, alloc_pred_taken,
           query_tag1, query_tag2,
           wb_valid, wb_tag, wb_value, wb_taken, wb_redirect_pc,
    output alloc_tag, full, query_ready1, query_ready2, query_value1, query_value2,
           commit_flag, commit_rd, commit_value, commit_tag, store_commit,
           rollback_flag, rollback_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: tag allocation, CDB capture, in-order commit, flush on mispredict.
// Optional ROB_BYPASS_EN: operand queries also see the concurrent CDB broadcast.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_W     = 5,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  reorder_buffer_if.slave rob
);
  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [1:0]        typ;
    logic [REG_W-1:0]  rd;
    logic              pred_taken;
    logic              taken;
    logic [DATA_W-1:0] value;
    logic [31:0]       redirect_pc;
  } entry_t;

  entry_t             ent [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] busy, ready;
  logic [IDX_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;

  logic              commit_flag_q, store_commit_q, rollback_flag_q;
  logic [REG_W-1:0]  commit_rd_q;
  logic [DATA_W-1:0] commit_value_q;
  logic [ROB_W-1:0]  commit_tag_q;
  logic [31:0]       rollback_pc_q;

  function automatic logic tag_ok(input logic [ROB_W-1:0] t);
    return (t != '0) && (t <= ROB_W'(ROB_DEPTH));
  endfunction

  // tag t lives at index t-1; tag ROB_DEPTH wraps to the last index
  function automatic logic [IDX_W-1:0] tag2idx(input logic [ROB_W-1:0] t);
    return t[IDX_W-1:0] - IDX_W'(1);
  endfunction

  entry_t           head_ent;
  logic [IDX_W-1:0] wb_idx;
  logic             full, do_commit, do_rollback, do_alloc, do_wb;

  assign head_ent    = ent[head];
  assign wb_idx      = tag2idx(rob.wb_tag);
  assign full        = (count == CNT_W'(ROB_DEPTH));
  assign do_commit   = rdy_in && busy[head] && ready[head];
  assign do_rollback = do_commit && (head_ent.typ == 2'd1) &&
                       (head_ent.taken != head_ent.pred_taken);
  // full is the registered view, so a same-cycle retire never frees a slot early
  assign do_alloc    = rdy_in && rob.alloc_valid && !full && !do_rollback;
  assign do_wb       = rdy_in && rob.wb_valid && tag_ok(rob.wb_tag) &&
                       busy[wb_idx] && !do_rollback;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      busy            <= '0;
      ready           <= '0;
      commit_flag_q   <= 1'b0;
      store_commit_q  <= 1'b0;
      rollback_flag_q <= 1'b0;
      commit_rd_q     <= '0;
      commit_value_q  <= '0;
      commit_tag_q    <= '0;
      rollback_pc_q   <= '0;
    end else begin
      commit_flag_q   <= 1'b0;
      store_commit_q  <= 1'b0;
      rollback_flag_q <= 1'b0;
      if (do_commit) begin
        commit_flag_q  <= 1'b1;
        commit_rd_q    <= (head_ent.typ == 2'd2) ? '0 : head_ent.rd;
        commit_value_q <= head_ent.value;
        commit_tag_q   <= ROB_W'(head) + ROB_W'(1);
        store_commit_q <= (head_ent.typ == 2'd2);
      end
      if (do_rollback) begin
        rollback_flag_q <= 1'b1;
        rollback_pc_q   <= head_ent.redirect_pc;
        head            <= '0;
        tail            <= '0;
        count           <= '0;
        busy            <= '0;
        ready           <= '0;
      end else begin
        if (do_alloc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + IDX_W'(1);
        end
        if (do_wb) ready[wb_idx] <= 1'b1;
        if (do_commit) begin
          busy[head] <= 1'b0;
          head       <= head + IDX_W'(1);
        end
        count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
      end
    end
  end

  // payload needs no reset: it is only observed through busy/ready
  always_ff @(posedge clk_in) begin
    if (do_alloc) begin
      ent[tail].typ        <= rob.alloc_type;
      ent[tail].rd         <= rob.alloc_rd;
      ent[tail].pred_taken <= rob.alloc_pred_taken;
    end
    if (do_wb) begin
      ent[wb_idx].value       <= rob.wb_value;
      ent[wb_idx].taken       <= rob.wb_taken;
      ent[wb_idx].redirect_pc <= rob.wb_redirect_pc;
    end
  end

  logic [1:0][ROB_W-1:0]  q_tag;
  logic [1:0]             q_rdy;
  logic [1:0][DATA_W-1:0] q_val;

  assign q_tag[0] = rob.query_tag1;
  assign q_tag[1] = rob.query_tag2;

  for (genvar k = 0; k < 2; k++) begin : g_query
    logic [IDX_W-1:0]  qi;
    logic              hit, rdy_k;
    logic [DATA_W-1:0] val_k;
    always_comb begin
      qi    = tag2idx(q_tag[k]);
      hit   = tag_ok(q_tag[k]) && busy[qi];
      rdy_k = 1'b0;
      val_k = '0;
      if (hit && ready[qi]) begin
        rdy_k = 1'b1;
        val_k = ent[qi].value;
      end
`ifdef ROB_BYPASS_EN
      if (hit && rob.wb_valid && (rob.wb_tag == q_tag[k])) begin
        rdy_k = 1'b1;
        val_k = rob.wb_value;
      end
`endif
    end
    assign q_rdy[k] = rdy_k;
    assign q_val[k] = val_k;
  end

  assign rob.query_ready1  = q_rdy[0];
  assign rob.query_ready2  = q_rdy[1];
  assign rob.query_value1  = q_val[0];
  assign rob.query_value2  = q_val[1];
  assign rob.alloc_tag     = ROB_W'(tail) + ROB_W'(1);
  assign rob.full          = full;
  assign rob.commit_flag   = commit_flag_q;
  assign rob.commit_rd     = commit_rd_q;
  assign rob.commit_value  = commit_value_q;
  assign rob.commit_tag    = commit_tag_q;
  assign rob.store_commit  = store_commit_q;
  assign rob.rollback_flag = rollback_flag_q;
  assign rob.rollback_pc   = rollback_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed plus random bench for reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  reorder_buffer_if #(.ROB_W(5), .DATA_W(32), .REG_W(5)) bus ();

  reorder_buffer #(.ROB_DEPTH(D), .ROB_W(5), .DATA_W(32), .REG_W(5)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob(bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          tag;
    int          rd;
    int          typ;
    bit          pred;
    bit          rdy;
    logic [31:0] val;
    bit          tkn;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   next_tag = 1;
  logic        e_cflag = 0, e_sc = 0, e_rb = 0;
  logic [31:0] e_crd = 0, e_cval = 0, e_ctag = 0, e_rbpc = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int find(input int t);
    foreach (q[i]) if (q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic exp_query(input int t, output logic r, output logic [31:0] v);
    int i;
    r = 1'b0; v = '0;
    i = find(t);
    if (i >= 0) begin
      if (q[i].rdy) begin r = 1'b1; v = q[i].val; end
`ifdef ROB_BYPASS_EN
      if (bus.wb_valid && int'(bus.wb_tag) == t) begin r = 1'b1; v = bus.wb_value; end
`endif
    end
  endtask

  task automatic model_reset();
    q.delete();
    next_tag = 1;
    e_cflag = 0; e_sc = 0; e_rb = 0;
    e_crd = 0; e_cval = 0; e_ctag = 0; e_rbpc = 0;
  endtask

  task automatic model_edge();
    bit   commit, full_pre;
    int   i;
    ent_t h, n;
    if (rst) begin model_reset(); return; end
    e_cflag = 0; e_sc = 0; e_rb = 0;
    if (!rdy) return;
    full_pre = (q.size() == D);
    commit   = (q.size() > 0) && q[0].rdy;
    if (commit) begin
      h = q[0];
      e_cflag = 1;
      e_crd   = (h.typ == 2) ? 0 : h.rd;
      e_cval  = h.val;
      e_ctag  = h.tag;
      e_sc    = (h.typ == 2);
      if (h.typ == 1 && h.tkn != h.pred) begin
        e_rb = 1; e_rbpc = h.pc;
        q.delete();
        next_tag = 1;
        return;
      end
    end
    if (bus.wb_valid) begin
      i = find(int'(bus.wb_tag));
      if (i >= 0) begin
        q[i].rdy = 1; q[i].val = bus.wb_value; q[i].tkn = bus.wb_taken; q[i].pc = bus.wb_redirect_pc;
      end
    end
    if (commit) void'(q.pop_front());
    if (bus.alloc_valid && !full_pre) begin
      n.tag = next_tag; n.rd = int'(bus.alloc_rd); n.typ = int'(bus.alloc_type);
      n.pred = bus.alloc_pred_taken; n.rdy = 0; n.val = 0; n.tkn = 0; n.pc = 0;
      q.push_back(n);
      next_tag = next_tag % D + 1;
    end
  endtask

  task automatic check_comb();
    logic r; logic [31:0] v;
    chk("alloc_tag", 32'(bus.alloc_tag), next_tag);
    chk("full", 32'(bus.full), 32'(q.size() == D));
    exp_query(int'(bus.query_tag1), r, v);
    chk("q1_ready", 32'(bus.query_ready1), 32'(r));
    chk("q1_value", bus.query_value1, v);
    exp_query(int'(bus.query_tag2), r, v);
    chk("q2_ready", 32'(bus.query_ready2), 32'(r));
    chk("q2_value", bus.query_value2, v);
  endtask

  task automatic check_regs();
    chk("commit_flag", 32'(bus.commit_flag), 32'(e_cflag));
    chk("commit_rd", 32'(bus.commit_rd), e_crd);
    chk("commit_value", bus.commit_value, e_cval);
    chk("commit_tag", 32'(bus.commit_tag), e_ctag);
    chk("store_commit", 32'(bus.store_commit), 32'(e_sc));
    chk("rollback_flag", 32'(bus.rollback_flag), 32'(e_rb));
    chk("rollback_pc", bus.rollback_pc, e_rbpc);
  endtask

  task automatic step();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    #1 check_regs();
  endtask

  task automatic idle();
    bus.alloc_valid = 0; bus.alloc_rd = 0; bus.alloc_type = 0; bus.alloc_pred_taken = 0;
    bus.wb_valid = 0; bus.wb_tag = 0; bus.wb_value = 0; bus.wb_taken = 0; bus.wb_redirect_pc = 0;
    bus.query_tag1 = 0; bus.query_tag2 = 0;
  endtask

  task automatic set_alloc(input int rd, input int typ, input bit pred);
    bus.alloc_valid = 1; bus.alloc_rd = 5'(rd); bus.alloc_type = 2'(typ); bus.alloc_pred_taken = pred;
  endtask

  task automatic set_wb(input int tag, input logic [31:0] val, input bit tkn, input logic [31:0] pc);
    bus.wb_valid = 1; bus.wb_tag = 5'(tag); bus.wb_value = val; bus.wb_taken = tkn; bus.wb_redirect_pc = pc;
  endtask

  // asynchronous reset asserted mid-cycle, held for two edges
  task automatic do_reset();
    idle();
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_count", 32'(dut.count), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_alloc_tag", 32'(bus.alloc_tag), 1);
    chk("rst_commit_flag", 32'(bus.commit_flag), 0);
    chk("rst_rollback_flag", 32'(bus.rollback_flag), 0);
    chk("rst_store_commit", 32'(bus.store_commit), 0);
    step();
    step();
    chk("rst_hold_count", 32'(dut.count), 0);
    rst = 0;
  endtask

  initial begin
    logic r_ex;
    idle();
    rdy = 1;
    rst = 1;
    #2;
    do_reset();

    // single allocate / writeback / retire
    set_alloc(3, 0, 0); step();
    idle(); set_wb(1, 32'h0000_00AA, 0, 0); step();
    chk("t2_no_early_commit", 32'(bus.commit_flag), 0);
    idle(); step();
    chk("t2_commit_flag", 32'(bus.commit_flag), 1);
    chk("t2_commit_rd", 32'(bus.commit_rd), 3);
    chk("t2_commit_value", bus.commit_value, 32'hAA);
    chk("t2_commit_tag", 32'(bus.commit_tag), 1);
    step();
    chk("t2_pulse_drop", 32'(bus.commit_flag), 0);

    // fill, overflow attempt, commit+alloc collision, wrap
    do_reset();
    for (int i = 0; i < D; i++) begin idle(); set_alloc(i + 1, 0, 0); step(); end
    chk("t3_full", 32'(bus.full), 1);
    idle(); set_alloc(9, 0, 0); step();
    chk("t3_ignored_count", 32'(dut.count), D);
    idle(); set_wb(1, 32'h1234, 0, 0); step();
    idle(); set_alloc(9, 0, 0); step();
    chk("t3_commit_tag", 32'(bus.commit_tag), 1);
    chk("t3_count_after", 32'(dut.count), D - 1);
    idle(); #1 chk("t3_tag_reuse", 32'(bus.alloc_tag), 1);
    set_alloc(7, 0, 0); step();
    chk("t3_full_again", 32'(bus.full), 1);

    // out-of-order writeback, in-order retire
    do_reset();
    for (int i = 0; i < 3; i++) begin idle(); set_alloc(i + 10, 0, 0); step(); end
    idle(); set_wb(3, 32'h33, 0, 0); step();
    idle(); set_wb(2, 32'h22, 0, 0); step();
    chk("t4_blocked", 32'(bus.commit_flag), 0);
    idle(); set_wb(1, 32'h11, 0, 0); step();
    idle(); step(); chk("t4_c1", 32'(bus.commit_tag), 1);
    step(); chk("t4_c2", 32'(bus.commit_tag), 2);
    step(); chk("t4_c3", 32'(bus.commit_tag), 3);
    chk("t4_c3_value", bus.commit_value, 32'h33);
    step(); chk("t4_idle", 32'(bus.commit_flag), 0);

    // reset mid-run with five busy entries
    for (int i = 0; i < 5; i++) begin idle(); set_alloc(i + 1, 0, 0); step(); end
    chk("t5_count5", 32'(dut.count), 5);
    do_reset();

    // mispredicted branch at head flushes everything
    idle(); set_alloc(0, 1, 0); step();
    for (int i = 0; i < 3; i++) begin idle(); set_alloc(i + 4, 0, 0); step(); end
    idle(); set_wb(1, 32'h0, 1, 32'h0000_1040); step();
    idle(); set_alloc(8, 0, 0); set_wb(2, 32'h77, 0, 0); step();
    chk("t6_rollback_flag", 32'(bus.rollback_flag), 1);
    chk("t6_rollback_pc", bus.rollback_pc, 32'h1040);
    idle(); #1;
    chk("t6_count", 32'(dut.count), 0);
    chk("t6_alloc_tag", 32'(bus.alloc_tag), 1);
    step();
    chk("t6_rb_drop", 32'(bus.rollback_flag), 0);

    // query racing a broadcast
    idle(); set_alloc(1, 0, 0); step();
    idle(); set_alloc(2, 0, 0); step();
    idle(); bus.query_tag1 = 2; set_wb(2, 32'h55, 0, 0); #1;
`ifdef ROB_BYPASS_EN
    r_ex = 1'b1;
`else
    r_ex = 1'b0;
`endif
    chk("t7_same_ready", 32'(bus.query_ready1), 32'(r_ex));
    chk("t7_same_value", bus.query_value1, r_ex ? 32'h55 : 32'h0);
    step();
    idle(); bus.query_tag1 = 2; #1;
    chk("t7_next_ready", 32'(bus.query_ready1), 1);
    chk("t7_next_value", bus.query_value1, 32'h55);
    step();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      int i;
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1)
        set_alloc(int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        bit tk;
        i  = int'($urandom_range(0, q.size() - 1));
        tk = (q[i].typ == 1 && $urandom_range(0, 7) == 0) ? !q[i].pred : q[i].pred;
        set_wb(q[i].tag, $urandom, tk, $urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        set_wb(int'($urandom_range(0, 20)), $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        bus.query_tag1 = 5'(q[$urandom_range(0, q.size() - 1)].tag);
      else
        bus.query_tag1 = 5'($urandom_range(0, 20));
      bus.query_tag2 = bus.wb_valid ? bus.wb_tag : 5'($urandom_range(0, 20));
      step();
    end
    rdy = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
